imm_encoder: RTL

//   Inverse of the immediate extender. It takes 32-bit values over a valid/ready stream.
//   For each value it finds the 16-bit immediate and 2-bit EOp that regenerate it exactly

---
 rtl/imm_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Inverse immediate extender: 32-bit value -> (imm, EOp, fit), queued in a DEPTH-entry FIFO.
// Latency: 1 cycle push-to-out_valid; in_ready drops when full, independent of out_ready.
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_fit,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        fit;
    } res_t;

    res_t             mem_q [DEPTH];
    res_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    res_t res_enc;
    res_t head;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Priority order matters: a value matching several EOps takes the first one.
    always_comb begin
        res_enc = '{imm: in_value[15:0], eop: 2'b00, fit: 1'b0};
        if (&in_value[31:15] || ~|in_value[31:15]) begin
            res_enc.fit = 1'b1;
        end else if (~|in_value[31:16]) begin
            res_enc.eop = 2'b01;
            res_enc.fit = 1'b1;
        end else if (~|in_value[15:0]) begin
            res_enc.imm = in_value[31:16];
            res_enc.eop = 2'b10;
            res_enc.fit = 1'b1;
        end else if (~|in_value[1:0] && (&in_value[31:17] || ~|in_value[31:17])) begin
            res_enc.imm = in_value[17:2];
            res_enc.eop = 2'b11;
            res_enc.fit = 1'b1;
        end
    end

    assign in_ready  = (count_q < OCC_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        miss_cnt_d = miss_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = res_enc;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            if (!res_enc.fit && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            miss_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Payload storage is never reset; out_valid gating hides stale entries.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_imm  = out_valid ? head.imm : '0;
    assign out_eop  = out_valid ? head.eop : '0;
    assign out_fit  = out_valid ? head.fit : 1'b0;
    assign miss_cnt = miss_cnt_q;

endmodule
